uart_tx_arbiter: RTL
====================

UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 SHALL have parameter NUM_REQ, default 4, giving the number of requesters (2..8).
REQ-002 SHALL have parameter BUSY_TIMEOUT, default 16, giving the maximum cycles to wait for uart_tx_busy after a start.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all logic rises on posedge clk.
REQ-004 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-005 SHALL have port req, input, NUM_REQ bits: bit i high means requester i holds a byte to send.
REQ-006 SHALL have port req_data, input, NUM_REQ*8 bits: byte i is bits [8i+7:8i].
REQ-007 SHALL have port req_lock, input, NUM_REQ bits: burst-hold request, used only under UART_ARB_LOCK_EN.
REQ-008 SHALL have port ack, output, NUM_REQ bits: one-cycle pulse, byte of requester i accepted.
REQ-009 SHALL have port grant, output, NUM_REQ bits: one-hot owner of the transmitter, zero when idle.
REQ-010 SHALL have port uart_tx_start, output, 1 bit: start pulse to the transmitter.
REQ-011 SHALL have port uart_tx_data, output, 8 bits: byte to the transmitter.
REQ-012 SHALL have port uart_tx_busy, input, 1 bit: transmitter busy flag.
REQ-013 SHALL have port arb_busy, output, 1 bit: high in any state other than IDLE.
REQ-014 SHALL have port err_timeout, output, 1 bit: one-cycle pulse on busy-wait timeout.

Function
REQ-015 SHALL implement the FSM IDLE -> ISSUE -> WAIT_BUSY -> WAIT_DONE -> IDLE.
REQ-016 IDLE: if any req bit is high and uart_tx_busy=0 in cycle n, SHALL pick the winner, latch its byte and enter ISSUE at n+1; otherwise SHALL stay in IDLE.
REQ-017 ISSUE (exactly 1 cycle): uart_tx_start=1, uart_tx_data=latched byte, grant=winner, ack=winner pulse.
REQ-018 WAIT_BUSY: on uart_tx_busy=1, SHALL go to WAIT_DONE.
REQ-019 WAIT_BUSY timeout: after BUSY_TIMEOUT cycles without busy, SHALL pulse err_timeout for one cycle and go to IDLE; the byte is dropped and not retried.
REQ-020 WAIT_DONE: on uart_tx_busy=0, SHALL go to IDLE; grant SHALL stay held through WAIT_BUSY and WAIT_DONE.
REQ-021 Selection SHALL be round-robin: search starts at (last_winner+1) mod NUM_REQ; the pointer updates only on entering ISSUE.
REQ-022 Request changes outside IDLE SHALL be ignored; a deasserted req never produces ack.
REQ-023 uart_tx_data SHALL hold the latched byte from ISSUE until the next ISSUE.
REQ-024 A requester SHALL keep req and req_data stable until its ack; a byte is consumed per ack.

Reset
REQ-025 rst=1 at a clock edge SHALL force IDLE, last_winner=NUM_REQ-1 (requester 0 first), and clear the timeout counter, plus grant, ack, uart_tx_start, uart_tx_data, err_timeout and arb_busy to 0.
REQ-026 Reset mid-transfer SHALL abandon the transfer; after release the FSM SHALL wait in IDLE until uart_tx_busy=0.

Configuration
REQ-027 Macro UART_ARB_LOCK_EN defined: leaving WAIT_DONE, if req[g]=1 and req_lock[g]=1 for current owner g, g SHALL win the next IDLE arbitration regardless of the pointer, and the pointer SHALL not advance.
REQ-028 UART_ARB_LOCK_EN undefined: req_lock SHALL be ignored and pure round-robin applies.

Structure
REQ-029 A shared package uart_arb_pkg SHALL hold the FSM state encoding (IDLE=0, ISSUE=1, WAIT_BUSY=2, WAIT_DONE=3) and the NUM_REQ/BUSY_TIMEOUT defaults.
REQ-030 Round-robin selection SHALL live in one sub-module, uart_rr_pick (req, pointer -> one-hot winner, valid).
REQ-031 The block SHALL connect to uart_tx/uart_rx through uart_top-level wiring, with no change to those modules.

Verification
REQ-032 Single: req=0001, data0=0x5A -> ack[0] and tx_start one cycle later, uart_tx_data=0x5A, serial line sends 0x5A, grant=0 after busy falls.
REQ-033 Fairness: req=1111 held for 8 bytes -> grant order 0,1,2,3,0,1,2,3.
REQ-034 Timeout: uart_tx_busy tied 0, req=0010 -> err_timeout pulse 16 cycles after WAIT_BUSY entry, then IDLE.
REQ-035 Reset mid-byte: rst pulsed in WAIT_DONE -> all outputs 0 next cycle, no new tx_start while uart_tx_busy=1.
REQ-036 Lock (macro on): req=0011, req_lock=0001 -> requester 0 granted repeatedly until req_lock[0]=0, then requester 1; macro off -> alternates 0,1.

Source files
------------

// File: rtl/uart_arb_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : uart_arb_pkg
//  Purpose  : Shared definitions for the UART transmit arbiter: FSM state
//             encoding and default sizing parameters.
//  Revision : 1.0 - initial release
// ============================================================================
package uart_arb_pkg;

    localparam int NUM_REQ_DEF      = 4;
    localparam int BUSY_TIMEOUT_DEF = 16;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        ISSUE     = 2'd1,
        WAIT_BUSY = 2'd2,
        WAIT_DONE = 2'd3
    } arb_state_t;

endpackage
`default_nettype wire

// File: rtl/uart_rr_pick.sv
`default_nettype none
// ============================================================================
//  Module   : uart_rr_pick
//  Purpose  : Round-robin picker. Searches req_i starting one position past
//             the last winner (ptr_i) and returns the first requester found
//             as a one-hot vector plus its index.
//  Revision : 1.0 - initial release
// ============================================================================
module uart_rr_pick
    import uart_arb_pkg::*;
#(
    parameter int NUM_REQ = NUM_REQ_DEF,
    parameter int PTR_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [PTR_W-1:0]   ptr_i,
    output logic [NUM_REQ-1:0] grant_o,
    output logic [PTR_W-1:0]   idx_o,
    output logic               valid_o
);

    int cand;

    // Walk the requesters in rotating order and keep the first hit.
    always_comb begin
        grant_o = '0;
        idx_o   = '0;
        valid_o = 1'b0;
        cand    = 0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            cand = (int'(ptr_i) + k) % NUM_REQ;
            if (!valid_o && req_i[cand]) begin
                valid_o       = 1'b1;
                grant_o[cand] = 1'b1;
                idx_o         = PTR_W'(cand);
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/uart_tx_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : uart_tx_arbiter
//  Purpose  : Round-robin arbiter sharing one UART transmitter among
//             NUM_REQ byte requesters. Issues a start pulse, waits for the
//             transmitter to go busy (with timeout) and then idle again.
//  Options  : UART_ARB_LOCK_EN - lets the current owner keep the transmitter
//             for back-to-back bytes while it holds req_lock.
//  Revision : 1.0 - initial release
// ============================================================================
module uart_tx_arbiter
    import uart_arb_pkg::*;
#(
    parameter int NUM_REQ      = NUM_REQ_DEF,
    parameter int BUSY_TIMEOUT = BUSY_TIMEOUT_DEF
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NUM_REQ-1:0]   req,
    input  logic [NUM_REQ*8-1:0] req_data,
    input  logic [NUM_REQ-1:0]   req_lock,
    output logic [NUM_REQ-1:0]   ack,
    output logic [NUM_REQ-1:0]   grant,
    output logic                 uart_tx_start,
    output logic [7:0]           uart_tx_data,
    input  logic                 uart_tx_busy,
    output logic                 arb_busy,
    output logic                 err_timeout
);

    localparam int PTR_W = $clog2(NUM_REQ);
    localparam int CNT_W = $clog2(BUSY_TIMEOUT + 1);

    // ptr_q is both the round-robin pointer (last winner) and, outside IDLE,
    // the index of the current owner.
    arb_state_t         state_q, state_d;
    logic [PTR_W-1:0]   ptr_q,   ptr_d;
    logic [7:0]         data_q,  data_d;
    logic [CNT_W-1:0]   cnt_q,   cnt_d;
    logic               err_q,   err_d;

    logic [NUM_REQ-1:0] w_pick_onehot;
    logic [PTR_W-1:0]   w_pick_idx;
    logic               w_pick_valid;
    logic [7:0]         w_pick_byte;
    logic [NUM_REQ-1:0] w_owner;
    logic               w_lock_win;

    uart_rr_pick #(
        .NUM_REQ (NUM_REQ),
        .PTR_W   (PTR_W)
    ) u_pick (
        .req_i   (req),
        .ptr_i   (ptr_q),
        .grant_o (w_pick_onehot),
        .idx_o   (w_pick_idx),
        .valid_o (w_pick_valid)
    );

`ifdef UART_ARB_LOCK_EN
    logic lock_q, lock_d;
    // A held lock only wins while the owner is still requesting.
    assign w_lock_win = lock_q & req[ptr_q];
`else
    logic w_unused_lock;
    assign w_lock_win    = 1'b0;
    assign w_unused_lock = ^req_lock;
`endif

    // AND-OR mux of the winning requester's byte.
    always_comb begin
        w_pick_byte = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (w_pick_onehot[i]) begin
                w_pick_byte = w_pick_byte | req_data[i*8 +: 8];
            end
        end
    end

    // Next-state logic for the IDLE -> ISSUE -> WAIT_BUSY -> WAIT_DONE cycle.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        data_d  = data_q;
        cnt_d   = cnt_q;
        err_d   = 1'b0;
`ifdef UART_ARB_LOCK_EN
        lock_d  = lock_q;
`endif
        case (state_q)
            IDLE: begin
                if (!uart_tx_busy) begin
                    if (w_lock_win) begin
                        // Owner keeps the transmitter; pointer stays put.
                        data_d  = req_data[int'(ptr_q)*8 +: 8];
                        state_d = ISSUE;
                    end else if (w_pick_valid) begin
                        ptr_d   = w_pick_idx;
                        data_d  = w_pick_byte;
                        state_d = ISSUE;
                    end
                end
            end
            ISSUE: begin
                cnt_d   = '0;
                state_d = WAIT_BUSY;
`ifdef UART_ARB_LOCK_EN
                lock_d  = 1'b0;
`endif
            end
            WAIT_BUSY: begin
                if (uart_tx_busy) begin
                    state_d = WAIT_DONE;
                end else if (cnt_q == CNT_W'(BUSY_TIMEOUT - 1)) begin
                    // Transmitter never responded: drop the byte.
                    err_d   = 1'b1;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            WAIT_DONE: begin
                if (!uart_tx_busy) begin
                    state_d = IDLE;
`ifdef UART_ARB_LOCK_EN
                    lock_d  = req[ptr_q] & req_lock[ptr_q];
`endif
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State register with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            ptr_q   <= PTR_W'(NUM_REQ - 1);
            data_q  <= '0;
            cnt_q   <= '0;
            err_q   <= 1'b0;
`ifdef UART_ARB_LOCK_EN
            lock_q  <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            data_q  <= data_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
`ifdef UART_ARB_LOCK_EN
            lock_q  <= lock_d;
`endif
        end
    end

    assign w_owner       = {{(NUM_REQ-1){1'b0}}, 1'b1} << ptr_q;
    assign arb_busy      = (state_q != IDLE);
    assign uart_tx_start = (state_q == ISSUE);
    assign grant         = arb_busy ? w_owner : '0;
    assign ack           = uart_tx_start ? w_owner : '0;
    assign uart_tx_data  = data_q;
    assign err_timeout   = err_q;

endmodule
`default_nettype wire
